// File: rtl/blc_pkg.sv
// Shared types and helpers for the black-level correction chain:
// FSM state enum, channel index constants and width/slice helpers.
package blc_pkg;

  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Channel indices within a packed {R,G,B} pixel (R in the MSBs)
  localparam int CH_R   = 2;
  localparam int CH_G   = 1;
  localparam int CH_B   = 0;
  localparam int NUM_CH = 3;

  // Accumulator width that holds 2^log2_samples full-scale samples without overflow
  function automatic int acc_width(input int data_width, input int log2_samples);
    return data_width + log2_samples;
  endfunction

  // LSB position of channel ch within a packed {R,G,B} bus
  function automatic int ch_lsb(input int ch, input int data_width);
    return ch * data_width;
  endfunction

endpackage

// File: rtl/blc_ob_channel_acc.sv
// Per-channel optical-black accumulator with averaging shift.
// BLC_OB_ROUND_EN selects round-half-up instead of truncation.
module blc_ob_channel_acc
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] avg
);

  localparam int AW = acc_width(DATA_WIDTH, LOG2_SAMPLES);

`ifdef BLC_OB_ROUND_EN
  localparam int unsigned ROUND_VAL = 32'd1 << (LOG2_SAMPLES - 1);
`else
  localparam int unsigned ROUND_VAL = 32'd0;
`endif

  logic [AW-1:0] acc_r;
  logic [AW-1:0] sum_s;
  logic [AW-1:0] rnd_s;

  // The final sample is folded in here, so the average is ready on the same edge
  assign sum_s = acc_r + AW'(sample);
  assign rnd_s = sum_s + AW'(ROUND_VAL);
  assign avg   = DATA_WIDTH'(rnd_s >> LOG2_SAMPLES);

  // Accumulator register: clear at window end, add on each non-final OB sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (add_en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/blc_ob_estimator.sv
// Black-level offset estimator: averages 2^LOG2_SAMPLES OB pixels per channel
// and presents the result with an insert/remove handshake (macro BLC_OB_ROUND_EN).
module blc_ob_estimator
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    u_i_ready,
  input  logic                    u_r_ready,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  input  logic                    ob_flag,
  output logic [3*DATA_WIDTH-1:0] offset_out,
  output logic                    i_i_ready,
  output logic                    i_r_ready,
  output logic [LOG2_SAMPLES-1:0] sample_cnt
);

  if (LOG2_SAMPLES < 1 || LOG2_SAMPLES > 8) begin : g_bad_log2
    $error("blc_ob_estimator: LOG2_SAMPLES must be in 1..8");
  end

  localparam logic [LOG2_SAMPLES-1:0] CNT_ONE  = LOG2_SAMPLES'(1);
  localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;

  state_t                                state_r;
  logic                                  i_i_ready_r;
  logic                                  i_r_ready_r;
  logic [LOG2_SAMPLES-1:0]               cnt_r;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     offset_r;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     avg_s;

  logic insert_s;
  logic remove_s;
  logic ob_ins_s;
  logic last_s;
  logic add_en_s;

  assign insert_s = u_i_ready && i_i_ready_r;
  assign remove_s = u_r_ready && i_r_ready_r;
  assign ob_ins_s = insert_s && ob_flag;
  assign last_s   = ob_ins_s && (cnt_r == CNT_LAST);
  assign add_en_s = ob_ins_s && !last_s;

  for (genvar c = CH_B; c <= CH_R; c++) begin : g_ch
    blc_ob_channel_acc #(
      .DATA_WIDTH  (DATA_WIDTH),
      .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_acc (
      .clock (clock),
      .reset (reset),
      .add_en(add_en_s),
      .clr   (last_s),
      .sample(data_in[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .avg   (avg_s[c])
    );
  end

  // Window FSM, sample counter, handshake flags and the held offset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ACCUM;
      i_i_ready_r <= 1'b1;
      i_r_ready_r <= 1'b0;
      cnt_r       <= '0;
      offset_r    <= '0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (last_s) begin
            offset_r    <= avg_s;
            cnt_r       <= '0;
            state_r     <= PRESENT;
            i_i_ready_r <= 1'b0;
            i_r_ready_r <= 1'b1;
          end else if (ob_ins_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        PRESENT: begin
          if (remove_s) begin
            state_r     <= ACCUM;
            i_i_ready_r <= 1'b1;
            i_r_ready_r <= 1'b0;
          end else begin
            state_r <= PRESENT;
          end
        end
        default: begin
          state_r     <= ACCUM;
          i_i_ready_r <= 1'b1;
          i_r_ready_r <= 1'b0;
          cnt_r       <= '0;
        end
      endcase
    end
  end

  assign offset_out = offset_r;
  assign i_i_ready  = i_i_ready_r;
  assign i_r_ready  = i_r_ready_r;
  assign sample_cnt = cnt_r;

endmodule

// File: tb/tb_blc_ob_estimator.sv
// Directed self-checking bench for blc_ob_estimator (DATA_WIDTH=12, LOG2_SAMPLES=2);
// expectations follow BLC_OB_ROUND_EN when the bench is built with it.
module tb_blc_ob_estimator;

  localparam int DW = 12;
  localparam int L  = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            u_i_ready = 1'b0;
  logic            u_r_ready = 1'b0;
  logic [3*DW-1:0] data_in = '0;
  logic            ob_flag = 1'b0;
  logic [3*DW-1:0] offset_out;
  logic            i_i_ready;
  logic            i_r_ready;
  logic [L-1:0]    sample_cnt;

  int n_pass  = 0;
  int n_total = 0;

  blc_ob_estimator #(.DATA_WIDTH(DW), .LOG2_SAMPLES(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .u_i_ready (u_i_ready),
    .u_r_ready (u_r_ready),
    .data_in   (data_in),
    .ob_flag   (ob_flag),
    .offset_out(offset_out),
    .i_i_ready (i_i_ready),
    .i_r_ready (i_r_ready),
    .sample_cnt(sample_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One insert cycle; outputs are checked by the caller #1 after the edge
  task automatic ins(input logic ob, input logic [DW-1:0] r, input logic [DW-1:0] g,
                     input logic [DW-1:0] b);
    u_i_ready = 1'b1;
    ob_flag   = ob;
    data_in   = {r, g, b};
    @(posedge clock);
    #1;
    u_i_ready = 1'b0;
    ob_flag   = 1'b0;
  endtask

  task automatic rem();
    u_r_ready = 1'b1;
    @(posedge clock);
    #1;
    u_r_ready = 1'b0;
  endtask

  function automatic logic [63:0] px(input int r, input int g, input int b);
    logic [DW-1:0] rr, gg, bb;
    rr = DW'(r);
    gg = DW'(g);
    bb = DW'(b);
    return 64'({rr, gg, bb});
  endfunction

  logic [63:0] held;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_i_i_ready", 64'(i_i_ready), 64'(1'b1));
    chk("rst_i_r_ready", 64'(i_r_ready), 64'(1'b0));
    chk("rst_offset", 64'(offset_out), 64'(0));
    chk("rst_cnt", 64'(sample_cnt), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Uniform window
    ins(1'b1, 12'd64, 12'd128, 12'd256);
    ins(1'b1, 12'd64, 12'd128, 12'd256);
    ins(1'b1, 12'd64, 12'd128, 12'd256);
    chk("uni_cnt3", 64'(sample_cnt), 64'(3));
    chk("uni_not_ready", 64'(i_r_ready), 64'(1'b0));
    ins(1'b1, 12'd64, 12'd128, 12'd256);
    chk("uni_i_r_ready", 64'(i_r_ready), 64'(1'b1));
    chk("uni_i_i_ready", 64'(i_i_ready), 64'(1'b0));
    chk("uni_offset", 64'(offset_out), px(64, 128, 256));
    chk("uni_cnt0", 64'(sample_cnt), 64'(0));

    // Backpressure: hold off removal, and offer OB inserts that must be ignored
    held = 64'(offset_out);
    u_i_ready = 1'b1;
    ob_flag   = 1'b1;
    data_in   = {12'd1, 12'd1, 12'd1};
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_i_r_ready", 64'(i_r_ready), 64'(1'b1));
      chk("bp_i_i_ready", 64'(i_i_ready), 64'(1'b0));
      chk("bp_offset", 64'(offset_out), held);
      chk("bp_cnt", 64'(sample_cnt), 64'(0));
    end
    u_r_ready = 1'b1;
    @(posedge clock);
    #1;
    u_r_ready = 1'b0;
    u_i_ready = 1'b0;
    ob_flag   = 1'b0;
    chk("rm_i_i_ready", 64'(i_i_ready), 64'(1'b1));
    chk("rm_i_r_ready", 64'(i_r_ready), 64'(1'b0));
    chk("rm_offset_persist", 64'(offset_out), px(64, 128, 256));
    chk("rm_cnt", 64'(sample_cnt), 64'(0));

    // Rounding: R sum 7, G sum 11, B sum 0
    ins(1'b1, 12'd1, 12'd3, 12'd0);
    ins(1'b1, 12'd2, 12'd3, 12'd0);
    ins(1'b1, 12'd2, 12'd3, 12'd0);
    ins(1'b1, 12'd2, 12'd2, 12'd0);
    chk("rnd_ready", 64'(i_r_ready), 64'(1'b1));
`ifdef BLC_OB_ROUND_EN
    chk("rnd_offset", 64'(offset_out), px(2, 3, 0));
`else
    chk("rnd_offset", 64'(offset_out), px(1, 2, 0));
`endif
    rem();

    // Full scale, no wrap
    for (int i = 0; i < 4; i++) ins(1'b1, 12'd4095, 12'd4095, 12'd4095);
    chk("fs_ready", 64'(i_r_ready), 64'(1'b1));
    chk("fs_offset", 64'(offset_out), px(4095, 4095, 4095));
    rem();

    // Non-OB interleave with u_r_ready held high (ignored while accumulating)
    u_r_ready = 1'b1;
    ins(1'b1, 12'd10, 12'd10, 12'd10);
    chk("nob_cnt_a", 64'(sample_cnt), 64'(1));
    ins(1'b0, 12'd999, 12'd999, 12'd999);
    chk("nob_cnt_b", 64'(sample_cnt), 64'(1));
    ins(1'b1, 12'd10, 12'd10, 12'd10);
    chk("nob_cnt_c", 64'(sample_cnt), 64'(2));
    ins(1'b0, 12'd999, 12'd999, 12'd999);
    chk("nob_cnt_d", 64'(sample_cnt), 64'(2));
    ins(1'b1, 12'd10, 12'd10, 12'd10);
    chk("nob_cnt_e", 64'(sample_cnt), 64'(3));
    chk("nob_r_ready_accum", 64'(i_r_ready), 64'(1'b0));
    ins(1'b1, 12'd10, 12'd10, 12'd10);
    chk("nob_cnt_f", 64'(sample_cnt), 64'(0));
    chk("nob_ready", 64'(i_r_ready), 64'(1'b1));
    chk("nob_offset", 64'(offset_out), px(10, 10, 10));
    // u_r_ready still high: removal on the very next edge
    @(posedge clock);
    #1;
    u_r_ready = 1'b0;
    chk("nob_back_accum", 64'(i_i_ready), 64'(1'b1));
    chk("nob_r_clear", 64'(i_r_ready), 64'(1'b0));

    // Reset mid-window after two samples of 100
    ins(1'b1, 12'd100, 12'd100, 12'd100);
    ins(1'b1, 12'd100, 12'd100, 12'd100);
    chk("mid_cnt2", 64'(sample_cnt), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(sample_cnt), 64'(0));
    chk("mid_rst_offset", 64'(offset_out), 64'(0));
    chk("mid_rst_i_i_ready", 64'(i_i_ready), 64'(1'b1));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) ins(1'b1, 12'd20, 12'd20, 12'd20);
    chk("post_no_early", 64'(i_r_ready), 64'(1'b0));
    ins(1'b1, 12'd20, 12'd20, 12'd20);
    chk("post_ready", 64'(i_r_ready), 64'(1'b1));
    chk("post_offset", 64'(offset_out), px(20, 20, 20));
    rem();
    chk("post_accum", 64'(i_i_ready), 64'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blc_ob_estimator.md
# blc_ob_estimator

Black-level offset estimator that sits directly upstream of the BLC correction chain. It accumulates optical-black (OB) pixels for each of the R, G and B channels over a window of 2^LOG2_SAMPLES flagged samples. At the end of each window it presents the per-channel average as `offset_out`, which drives `offset_in` of the first BLC stage. It uses the same insert/remove ready handshake as the BLC stages, and it honours downstream backpressure.

## Interface
- `DATA_WIDTH`, default 12: bits per colour channel.
- `LOG2_SAMPLES`, default 4: log2 of the number of OB samples averaged per window. Legal range is 1..8.
- `clock`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `u_i_ready`  input  1: upstream has a pixel to insert.
- `u_r_ready`  input  1: downstream is ready to remove the presented offset.
- `data_in`  input  3*DATA_WIDTH: pixel packed as {R,G,B}, with R in the MSBs.
- `ob_flag`  input  1: `data_in` is an optical-black pixel. Sampled only on insert.
- `offset_out`  output  3*DATA_WIDTH: averaged offset packed as {R,G,B}.
- `i_i_ready`  output  1: block accepts an insert.
- `i_r_ready`  output  1: `offset_out` holds a fresh window result.
- `sample_cnt`  output  LOG2_SAMPLES: number of OB samples accumulated in the current window.

## Operation
- Event definitions:
  - insert = `u_i_ready && i_i_ready`.
  - remove = `u_r_ready && i_r_ready`.
- Reset values (asynchronous, taking effect while `reset` = 0):
  - state = ACCUM.
  - `i_i_ready` = 1, `i_r_ready` = 0.
  - `offset_out` = 0, `sample_cnt` = 0.
  - All accumulators = 0.
- Accumulators: three per-channel accumulators, each DATA_WIDTH+LOG2_SAMPLES bits wide. They are unsigned and cannot overflow.
- State ACCUM (`i_i_ready` = 1, `i_r_ready` = 0):
  - Insert with `ob_flag` = 0: pixel is accepted and discarded. No state change.
  - Insert with `ob_flag` = 1 and `sample_cnt` < 2^L−1: each channel value is added to its accumulator, and `sample_cnt` increments.
  - Insert with `ob_flag` = 1 and `sample_cnt` = 2^L−1: this is the final sample.
    - `offset_out` ← (acc + sample [+ round]) >> L, computed per channel.
    - Accumulators and `sample_cnt` clear.
    - Next state is PRESENT.
- State PRESENT (`i_i_ready` = 0, `i_r_ready` = 1):
  - Inserts are impossible.
  - `offset_out` is held stable.
  - On remove, the next state is ACCUM.
- `offset_out` persists after removal. It is updated only at the next window completion or on reset.
- Result range: averaging never exceeds 2^DATA_WIDTH−1, with or without rounding, so no clamp is needed.
- Reset asserted mid-window: the partial window is discarded. The next window starts from zero.

## Timing
- Latency: the final-sample insert at edge N gives `i_r_ready` = 1 and a valid `offset_out` after edge N.
- Remove at edge M gives `i_i_ready` = 1 after edge M. The first new insert is therefore possible at edge M+1.
- Throughput: one insert per cycle in ACCUM. PRESENT lasts at least 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- `u_r_ready` is ignored in ACCUM. `u_i_ready` is ignored in PRESENT.

## Configuration
- Macro `BLC_OB_ROUND_EN`:
  - Defined: 2^(LOG2_SAMPLES−1) is added before the shift, giving round-half-up.
  - Undefined: the average is truncated (floor).
- The macro has no other effect on the interface or timing.

## Structure
- Shared package `blc_pkg` holds:
  - The state enum (ACCUM, PRESENT).
  - A channel-slice helper, with index constants R=2, G=1, B=0.
  - The accumulator-width function `acc_width(DATA_WIDTH, LOG2_SAMPLES)`.
- One sub-module, `blc_ob_channel_acc`, instantiated three times. It contains:
  - The accumulator register.
  - The add of the incoming sample.
  - The rounded or truncated shift.
  - Clear and load controls driven by the top-level FSM.
- The top level owns the FSM, `sample_cnt`, the handshake flags and `offset_out`.

## Test plan
All scenarios use DATA_WIDTH=12 and LOG2_SAMPLES=2 unless noted.
- Uniform window: 4 OB inserts of {64,128,256} → `i_r_ready` = 1 one cycle after the 4th insert, and `offset_out` = {64,128,256}.
- Rounding: R samples 1,2,2,2 (sum 7) → R offset = 1 without `BLC_OB_ROUND_EN` and 2 with it.
- Full scale: 4 samples of {4095,4095,4095} → `offset_out` = {4095,4095,4095} in both builds, with no wrap.
- Non-OB interleave: OB, non-OB(999), OB, non-OB, OB, OB with values 10,10,10,10 → offset = 10, and `sample_cnt` steps 1,1,2,2,3,0.
- Backpressure: hold `u_r_ready` = 0 for 5 cycles in PRESENT → `i_r_ready` stays 1, `i_i_ready` stays 0, and `offset_out` is stable. `u_r_ready` = 1 → ACCUM on the next cycle.
- Reset mid-window: reset after 2 samples of 100, then 4 samples of 20 → `offset_out` = 20, `sample_cnt` = 0 right after reset, and the old partial sum is not included.
